tile_bound_fetch: RTL and testbench

//  Per-frame wall lookup for the player block. On each rising edge of frame_clk, snapshots the four

---
 rtl/tile_bound_fetch_if.sv | 43 ++++
 rtl/tile_bound_fetch.sv | 169 ++++++++++++++++
 tb/tb_tile_bound_fetch.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_bound_fetch_if.sv
//------------------------------------------------------------------------------
// tile_bound_fetch_if : corner indices, tile-map RAM read port and bound outputs
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface tile_bound_fetch_if #(
    parameter int IDX_W = 12
);
    logic [IDX_W-1:0] tl_index;
    logic [IDX_W-1:0] tr_index;
    logic [IDX_W-1:0] bl_index;
    logic [IDX_W-1:0] br_index;

    logic [IDX_W-1:0] map_addr;
    logic             map_rd;
    logic [3:0]       map_data;

    logic [3:0]       tl_bound;
    logic [3:0]       tr_bound;
    logic [3:0]       bl_bound;
    logic [3:0]       br_bound;
    logic             bounds_valid;
    logic             busy;
    logic             oob_err;
    logic             overrun;

    modport master (
        input  tl_index, tr_index, bl_index, br_index, map_data,
        output map_addr, map_rd,
        output tl_bound, tr_bound, bl_bound, br_bound,
        output bounds_valid, busy, oob_err, overrun
    );

    modport slave (
        output tl_index, tr_index, bl_index, br_index, map_data,
        input  map_addr, map_rd,
        input  tl_bound, tr_bound, bl_bound, br_bound,
        input  bounds_valid, busy, oob_err, overrun
    );
endinterface

`default_nettype wire

// File: rtl/tile_bound_fetch.sv
//------------------------------------------------------------------------------
// tile_bound_fetch : per-frame fetch of the four player-corner wall nibbles
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tile_bound_fetch #(
    parameter int MAP_DEPTH = 300,
    parameter int IDX_W     = 12,
    parameter int RD_LAT    = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk,
    tile_bound_fetch_if.master  bus
);

    localparam logic [IDX_W:0] c_map_depth = (IDX_W+1)'(MAP_DEPTH);
    localparam logic [1:0]     c_last_wait = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic [1:0]       wcnt_q, wcnt_d;
    logic             issued_q, issued_d;
    logic             oob_q, oob_d;
    logic             overrun_q, overrun_d;
    logic [IDX_W-1:0] snap_q   [4];
    logic [IDX_W-1:0] snap_d   [4];
    logic [3:0]       shadow_q [4];
    logic [3:0]       shadow_d [4];
    logic [3:0]       bound_q  [4];
    logic [3:0]       bound_d  [4];

    logic             sync1_q, sync2_q, edge_q;
    logic             w_rise;
    logic             w_in_range;
    logic [IDX_W-1:0] w_map_addr;
    logic             w_map_rd;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign w_rise     = sync2_q & ~edge_q;
    assign w_in_range = ({1'b0, snap_q[k_q]} < c_map_depth);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            k_q       <= 2'd0;
            wcnt_q    <= 2'd0;
            issued_q  <= 1'b0;
            oob_q     <= 1'b0;
            overrun_q <= 1'b0;
            snap_q    <= '{default: '0};
            shadow_q  <= '{default: '0};
            bound_q   <= '{default: '0};
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            wcnt_q    <= wcnt_d;
            issued_q  <= issued_d;
            oob_q     <= oob_d;
            overrun_q <= overrun_d;
            snap_q    <= snap_d;
            shadow_q  <= shadow_d;
            bound_q   <= bound_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        wcnt_d     = wcnt_q;
        issued_d   = issued_q;
        oob_d      = oob_q;
        overrun_d  = overrun_q;
        snap_d     = snap_q;
        shadow_d   = shadow_q;
        bound_d    = bound_q;
        w_map_addr = '0;
        w_map_rd   = 1'b0;

        if (w_rise && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (w_rise) begin
                    snap_d[0] = bus.tl_index;
                    snap_d[1] = bus.tr_index;
                    snap_d[2] = bus.bl_index;
                    snap_d[3] = bus.br_index;
                    oob_d     = 1'b0;
                    k_d       = 2'd0;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                wcnt_d  = 2'd0;
                state_d = S_WAIT;
                if (w_in_range) begin
                    w_map_addr = snap_q[k_q];
                    w_map_rd   = 1'b1;
                    issued_d   = 1'b1;
                end else begin
                    // Off-map tiles behave as solid blocks; the slot is still spent.
                    shadow_d[k_q] = 4'hF;
                    oob_d         = 1'b1;
                    issued_d      = 1'b0;
                end
            end
            S_WAIT: begin
                if (wcnt_q == c_last_wait) begin
                    if (issued_q) begin
                        shadow_d[k_q] = bus.map_data;
                    end
                    if (k_q == 2'd3) begin
                        // Commit here so the new set is already visible during DONE.
                        bound_d = shadow_d;
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = S_REQ;
                    end
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_DONE: begin
                k_d     = 2'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.map_addr     = w_map_addr;
    assign bus.map_rd       = w_map_rd;
    assign bus.tl_bound     = bound_q[0];
    assign bus.tr_bound     = bound_q[1];
    assign bus.bl_bound     = bound_q[2];
    assign bus.br_bound     = bound_q[3];
    assign bus.bounds_valid = (state_q == S_DONE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.oob_err      = oob_q;
    assign bus.overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_tile_bound_fetch.sv
//------------------------------------------------------------------------------
// tb_tile_bound_fetch : two instances (RD_LAT 1 and 3) against a frame-level model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tile_bound_fetch;

    localparam int c_start = 3;
    localparam int c_depth = 300;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [11:0] idx [4];
    logic [3:0]  mem [4096];

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] exp_bounds [2];
    logic        exp_ovr;

    always #5 Clk = ~Clk;

    tile_bound_fetch_if #(.IDX_W(12)) bus0 ();
    tile_bound_fetch_if #(.IDX_W(12)) bus1 ();

    tile_bound_fetch #(.MAP_DEPTH(300), .IDX_W(12), .RD_LAT(1)) dut0 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .bus(bus0));
    tile_bound_fetch #(.MAP_DEPTH(300), .IDX_W(12), .RD_LAT(3)) dut1 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .bus(bus1));

    assign bus0.tl_index = idx[0];
    assign bus0.tr_index = idx[1];
    assign bus0.bl_index = idx[2];
    assign bus0.br_index = idx[3];
    assign bus1.tl_index = idx[0];
    assign bus1.tr_index = idx[1];
    assign bus1.bl_index = idx[2];
    assign bus1.br_index = idx[3];

    // Map RAM models: data appears RD_LAT cycles after a strobe, garbage otherwise.
    logic [3:0] pa;
    logic [3:0] pb [3];
    always @(posedge Clk) begin
        pa    <= bus0.map_rd ? mem[bus0.map_addr] : 4'($urandom);
        pb[0] <= bus1.map_rd ? mem[bus1.map_addr] : 4'($urandom);
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign bus0.map_data = pa;
    assign bus1.map_data = pb[2];

    logic        rd_v   [2];
    logic [11:0] ad_v   [2];
    logic        bv_v   [2];
    logic        busy_v [2];
    logic        oob_v  [2];
    logic        ovr_v  [2];
    logic [15:0] bnd_v  [2];
    assign rd_v[0]   = bus0.map_rd;       assign rd_v[1]   = bus1.map_rd;
    assign ad_v[0]   = bus0.map_addr;     assign ad_v[1]   = bus1.map_addr;
    assign bv_v[0]   = bus0.bounds_valid; assign bv_v[1]   = bus1.bounds_valid;
    assign busy_v[0] = bus0.busy;         assign busy_v[1] = bus1.busy;
    assign oob_v[0]  = bus0.oob_err;      assign oob_v[1]  = bus1.oob_err;
    assign ovr_v[0]  = bus0.overrun;      assign ovr_v[1]  = bus1.overrun;
    assign bnd_v[0]  = {bus0.tl_bound, bus0.tr_bound, bus0.bl_bound, bus0.br_bound};
    assign bnd_v[1]  = {bus1.tl_bound, bus1.tr_bound, bus1.bl_bound, bus1.br_bound};

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic idle_check(input int cycles);
        int nrd [2];
        int nbv [2];
        nrd = '{0, 0};
        nbv = '{0, 0};
        for (int c = 0; c < cycles; c++) begin
            @(posedge Clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (rd_v[i]) nrd[i]++;
                if (bv_v[i] || busy_v[i]) nbv[i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("idle_rd%0d", i), nrd[i], 0);
            check_val($sformatf("idle_act%0d", i), nbv[i], 0);
            check_val($sformatf("idle_bnd%0d", i), int'(bnd_v[i]), 0);
        end
    endtask

    task automatic run_frame(input bit ovr, input bit chg, input bit rst_mid);
        logic [11:0] snap [4];
        logic [3:0]  nib  [4];
        logic [15:0] exp_new;
        logic        exp_oob;
        int          s_obs [2];
        int          bv_c  [2];
        int          nbv   [2];
        int          glitch[2];
        int          nrd   [2];
        int          rd_cyc[2][8];
        logic [11:0] rd_adr[2][8];
        logic [15:0] prev  [2];
        logic [15:0] bnd_bv[2];
        logic        oob_bv[2];
        int          lat, ne, cyc_k;

        exp_oob = 1'b0;
        for (int k = 0; k < 4; k++) begin
            snap[k] = idx[k];
            if (int'(snap[k]) < c_depth) nib[k] = mem[snap[k]];
            else begin nib[k] = 4'hF; exp_oob = 1'b1; end
        end
        exp_new = {nib[0], nib[1], nib[2], nib[3]};
        if (ovr) exp_ovr = 1'b1;

        for (int i = 0; i < 2; i++) begin
            s_obs[i] = -1; bv_c[i] = -1; nbv[i] = 0; glitch[i] = 0; nrd[i] = 0;
            prev[i] = exp_bounds[i]; bnd_bv[i] = '0; oob_bv[i] = 1'b0;
        end

        frame_clk = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge Clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (busy_v[i] && s_obs[i] < 0) s_obs[i] = c;
                if (rd_v[i] && nrd[i] < 8) begin
                    rd_cyc[i][nrd[i]] = c;
                    rd_adr[i][nrd[i]] = ad_v[i];
                    nrd[i]++;
                end
                if (bv_v[i]) begin
                    nbv[i]++;
                    if (bv_c[i] < 0) begin
                        bv_c[i] = c; bnd_bv[i] = bnd_v[i]; oob_bv[i] = oob_v[i];
                    end
                end
                if (bnd_v[i] != prev[i] && !bv_v[i] && !(rst_mid && c >= c_start + 5))
                    glitch[i]++;
                prev[i] = bnd_v[i];
            end
            if (c == 2) frame_clk = 1'b0;
            if (ovr && c == c_start + 3) frame_clk = 1'b1;
            if (ovr && c == c_start + 5) frame_clk = 1'b0;
            if (chg && c == c_start + 1)
                for (int k = 0; k < 4; k++) idx[k] = 12'($urandom);
            if (rst_mid && c == c_start + 5) Reset = 1'b1;
            if (rst_mid && c == c_start + 6) Reset = 1'b0;
        end

        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 1 : 3;
            check_val($sformatf("start%0d", i), s_obs[i], c_start);
            ne = 0;
            for (int k = 0; k < 4; k++) begin
                cyc_k = c_start + k * (lat + 1);
                if (int'(snap[k]) < c_depth && (!rst_mid || cyc_k <= c_start + 5)) begin
                    if (ne < nrd[i]) begin
                        check_val($sformatf("rd_cyc%0d_k%0d", i, k), rd_cyc[i][ne], cyc_k);
                        check_val($sformatf("rd_adr%0d_k%0d", i, k), int'(rd_adr[i][ne]), int'(snap[k]));
                    end
                    ne++;
                end
            end
            check_val($sformatf("rd_cnt%0d", i), nrd[i], ne);
            check_val($sformatf("atomic%0d", i), glitch[i], 0);
            if (rst_mid) begin
                exp_bounds[i] = '0;
                check_val($sformatf("rst_bv%0d", i), nbv[i], 0);
                check_val($sformatf("rst_bnd%0d", i), int'(bnd_v[i]), 0);
                check_val($sformatf("rst_busy%0d", i), int'(busy_v[i]), 0);
                check_val($sformatf("rst_oob%0d", i), int'(oob_v[i]), 0);
                check_val($sformatf("rst_ovr%0d", i), int'(ovr_v[i]), 0);
            end else begin
                exp_bounds[i] = exp_new;
                check_val($sformatf("bv_cnt%0d", i), nbv[i], 1);
                check_val($sformatf("bv_cyc%0d", i), bv_c[i], c_start + 4 * (lat + 1));
                check_val($sformatf("bnd_bv%0d", i), int'(bnd_bv[i]), int'(exp_new));
                check_val($sformatf("oob%0d", i), int'(oob_bv[i]), int'(exp_oob));
                check_val($sformatf("bnd_hold%0d", i), int'(bnd_v[i]), int'(exp_new));
                check_val($sformatf("ovr%0d", i), int'(ovr_v[i]), int'(exp_ovr));
            end
        end
        if (rst_mid) exp_ovr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 4'($urandom);
        for (int k = 0; k < 4; k++) idx[k] = '0;
        exp_bounds = '{16'h0, 16'h0};
        exp_ovr    = 1'b0;

        repeat (3) @(posedge Clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("rst_bnd%0d", i), int'(bnd_v[i]), 0);
            check_val($sformatf("rst_stat%0d", i),
                      int'({rd_v[i], bv_v[i], busy_v[i], oob_v[i], ovr_v[i]}), 0);
            check_val($sformatf("rst_addr%0d", i), int'(ad_v[i]), 0);
        end
        Reset = 1'b0;
        idle_check(20);

        mem[21] = 4'h1; mem[22] = 4'h2; mem[41] = 4'h8; mem[42] = 4'h4;
        idx[0] = 12'd21; idx[1] = 12'd22; idx[2] = 12'd41; idx[3] = 12'd42;
        run_frame(1'b0, 1'b0, 1'b0);

        idx[1] = 12'd300; idx[3] = 12'd4095;
        run_frame(1'b0, 1'b0, 1'b0);

        idx[0] = 12'd5; idx[1] = 12'd299; idx[2] = 12'd120; idx[3] = 12'd0;
        run_frame(1'b1, 1'b0, 1'b0);
        idx[0] = 12'd7; idx[1] = 12'd8; idx[2] = 12'd27; idx[3] = 12'd28;
        run_frame(1'b0, 1'b0, 1'b0);

        idx[0] = 12'd60; idx[1] = 12'd61; idx[2] = 12'd80; idx[3] = 12'd81;
        run_frame(1'b0, 1'b1, 1'b1);
        idle_check(5);

        mem[0] = 4'hB;
        for (int k = 0; k < 4; k++) idx[k] = '0;
        run_frame(1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 30; f++) begin
            for (int k = 0; k < 4; k++)
                idx[k] = ($urandom_range(0, 4) == 0) ? 12'($urandom_range(300, 4095))
                                                     : 12'($urandom_range(0, 299));
            run_frame($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
